// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions for the message-schedule slice: word type, FSM
// states, round constant table and the schedule sigma functions.
package sha_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotations are written as concatenations so they map to pure wiring.
  function automatic word_t ssig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t ssig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha_k_rom.sv
// Combinational SHA-256 round constant lookup.
module sha_k_rom
  import sha_pkg::*;
(
  input  logic [5:0] idx,
  output word_t      k
);

  assign k = K_TABLE[idx];

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into ROUNDS words W[t]
// with matching K[t], streamed over a valid/ready handshake.
module sha_msg_schedule
  import sha_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         block_valid,
  input  logic [511:0] block_data,
  output logic         block_ready,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [31:0]  k_data,
  output logic [5:0]   round_idx,
  output logic         w_last
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  state_t     state_r, state_nxt_s;
  word_t      window_r [16];
  word_t      window_nxt_s [16];
  logic [5:0] t_r, t_nxt_s;
  logic       accept_s, xfer_s;
  word_t      k_s;
  logic       block_ready_nxt_s, w_valid_nxt_s, w_last_nxt_s;
  word_t      w_data_nxt_s, k_data_nxt_s;
  logic [5:0] round_idx_nxt_s;

  assign accept_s = (state_r == IDLE) && block_valid;
  assign xfer_s   = (state_r == RUN) && w_ready;

  // K is looked up for the next t so that k_data can be registered with the rest.
  sha_k_rom u_k_rom (
    .idx (t_nxt_s),
    .k   (k_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (block_valid) state_nxt_s = RUN;
        else             state_nxt_s = IDLE;
      end
      RUN: begin
        if (xfer_s && (t_r == T_LAST)) state_nxt_s = IDLE;
        else                           state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Window load / shift-and-expand and round counter update
  always_comb begin
    window_nxt_s = window_r;
    t_nxt_s      = t_r;
    if (accept_s) begin
      for (int i = 0; i < 16; i++) begin
        window_nxt_s[i] = block_data[511 - 32*i -: 32];
      end
      t_nxt_s = 6'd0;
    end else if (xfer_s && (t_r != T_LAST)) begin
      for (int i = 0; i < 15; i++) begin
        window_nxt_s[i] = window_r[i+1];
      end
      window_nxt_s[15] = ssig1(window_r[14]) + window_r[9] + ssig0(window_r[1]) + window_r[0];
      t_nxt_s = t_r + 6'd1;
    end else begin
      window_nxt_s = window_r;
      t_nxt_s      = t_r;
    end
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    block_ready_nxt_s = 1'b1;
    w_valid_nxt_s     = 1'b0;
    w_data_nxt_s      = 32'h0000_0000;
    k_data_nxt_s      = 32'h0000_0000;
    round_idx_nxt_s   = 6'd0;
    w_last_nxt_s      = 1'b0;
    if (state_nxt_s == RUN) begin
      block_ready_nxt_s = 1'b0;
      w_valid_nxt_s     = 1'b1;
      w_data_nxt_s      = window_nxt_s[0];
      k_data_nxt_s      = k_s;
      round_idx_nxt_s   = t_nxt_s;
      w_last_nxt_s      = (t_nxt_s == T_LAST);
    end else begin
      block_ready_nxt_s = 1'b1;
      w_valid_nxt_s     = 1'b0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_r    <= '{default: 32'h0000_0000};
      t_r         <= 6'd0;
      block_ready <= 1'b1;
      w_valid     <= 1'b0;
      w_data      <= 32'h0000_0000;
      k_data      <= 32'h0000_0000;
      round_idx   <= 6'd0;
      w_last      <= 1'b0;
    end else begin
      window_r    <= window_nxt_s;
      t_r         <= t_nxt_s;
      block_ready <= block_ready_nxt_s;
      w_valid     <= w_valid_nxt_s;
      w_data      <= w_data_nxt_s;
      k_data      <= k_data_nxt_s;
      round_idx   <= round_idx_nxt_s;
      w_last      <= w_last_nxt_s;
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Self-checking bench: recurrence-based schedule model checked every cycle,
// plus directed literal checks and an end-to-end SHA-256 "abc" digest.
module tb_sha_msg_schedule;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

  logic         clk = 1'b0;
  logic         rst;
  logic         block_valid, w_ready;
  logic [511:0] block_data;
  logic         block_ready, w_valid, w_last;
  logic [31:0]  w_data, k_data;
  logic [5:0]   round_idx;

  logic         bv16, wr16;
  logic [511:0] bd16;
  logic         br16, wv16, wl16;
  logic [31:0]  wd16, kd16;
  logic [5:0]   ri16;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] exp_w [64];
  logic        m_busy = 1'b0;
  int          m_t = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_wd, prev_kd;
  logic [5:0]  prev_ri;
  logic        prev_wl;
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];
  logic        cap_l [64];
  int          cap_n = 0;

  always #5 clk = ~clk;

  sha_msg_schedule #(.ROUNDS(64)) u_dut64 (
    .clk(clk), .rst(rst), .block_valid(block_valid), .block_data(block_data),
    .block_ready(block_ready), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .k_data(k_data), .round_idx(round_idx), .w_last(w_last)
  );

  sha_msg_schedule #(.ROUNDS(16)) u_dut16 (
    .clk(clk), .rst(rst), .block_valid(bv16), .block_data(bd16),
    .block_ready(br16), .w_valid(wv16), .w_ready(wr16),
    .w_data(wd16), .k_data(kd16), .round_idx(ri16), .w_last(wl16)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook recurrence over the full W array
  task automatic expand(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[511 - 32*t -: 32];
      else exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                    + exp_w[t-7]
                    + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                    + exp_w[t-16];
    end
  endtask

  task automatic digest(output logic [255:0] d);
    logic [31:0] iv [8];
    logic [31:0] a, b, c, e, f, g, h, dd, t1, t2;
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    a = iv[0]; b = iv[1]; c = iv[2]; dd = iv[3]; e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + cap_k[t] + cap_w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = dd + t1; dd = c; c = b; b = a; a = t1 + t2;
    end
    d = {iv[0] + a, iv[1] + b, iv[2] + c, iv[3] + dd, iv[4] + e, iv[5] + f, iv[6] + g, iv[7] + h};
  endtask

  // Compare process: checks the 64-round DUT every cycle, then advances the model
  always @(negedge clk) begin
    if (rst) begin
      check("rst_outputs", {block_ready, w_valid, w_last, w_data, k_data, round_idx},
            {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0});
      m_busy = 1'b0;
      m_t = 0;
      prev_stall = 1'b0;
    end else begin
      check("block_ready", block_ready, !m_busy);
      check("w_valid", w_valid, m_busy);
      if (m_busy) begin
        check("w_data", w_data, exp_w[m_t]);
        check("k_data", k_data, KT[m_t]);
        check("round_idx", round_idx, m_t[5:0]);
        check("w_last", w_last, m_t == 63);
      end else begin
        check("idle_zero", {w_data, k_data, round_idx, w_last}, 71'h0);
      end
      if (prev_stall) check("stall_stable", {w_data, k_data, round_idx, w_last},
                            {prev_wd, prev_kd, prev_ri, prev_wl});
      prev_stall = m_busy && !w_ready;
      prev_wd = w_data; prev_kd = k_data; prev_ri = round_idx; prev_wl = w_last;
      if (!m_busy) begin
        if (block_valid) begin
          expand(block_data);
          m_busy = 1'b1;
          m_t = 0;
        end
      end else if (w_ready) begin
        if (cap_n < 64) begin
          cap_w[cap_n] = w_data; cap_k[cap_n] = k_data; cap_l[cap_n] = w_last;
          cap_n++;
        end
        if (m_t == 63) m_busy = 1'b0;
        else m_t++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cap();
    int k = 0;
    while (cap_n < 64 && k < 3000) begin
      step();
      k++;
    end
    check("cap_done", cap_n, 64);
    repeat (3) step();
  endtask

  task automatic wait_last();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (w_last !== 1'b1 && k < 300);
    check("saw_w_last", w_last, 1'b1);
  endtask

  logic [511:0] blk2;
  logic [255:0] dg;
  int           k, nlast;

  initial begin
    for (int i = 0; i < 16; i++) blk2[511 - 32*i -: 32] = 32'hdeadbe00 + 32'h01000000 * i;
    rst = 1'b1; block_valid = 1'b0; block_data = '0; w_ready = 1'b1;
    bv16 = 1'b0; bd16 = '0; wr16 = 1'b1;
    #1;
    check("reset_async", {block_ready, w_valid, w_data, br16, wv16}, {1'b1, 1'b0, 32'h0, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    step();

    // "abc" block, w_ready held high
    cap_n = 0;
    block_valid = 1'b1; block_data = ABC_BLK;
    step();
    check("abc_lat1", {w_valid, w_data, k_data, round_idx}, {1'b1, 32'h61626380, 32'h428a2f98, 6'd0});
    block_valid = 1'b0;
    wait_cap();
    check("abc_w15", cap_w[15], 32'h00000018);
    check("abc_w16", cap_w[16], 32'h61626380);
    check("abc_w17", cap_w[17], 32'h000F0000);
    check("abc_k63", cap_k[63], 32'hc67178f2);
    nlast = 0;
    for (int i = 0; i < 64; i++) nlast += int'(cap_l[i]);
    check("abc_last_cnt", nlast, 1);
    check("abc_last63", cap_l[63], 1'b1);
    digest(dg);
    check("abc_digest", dg, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    // Backpressure with pseudo-random w_ready
    cap_n = 0;
    block_valid = 1'b1; block_data = ABC_BLK;
    step();
    block_valid = 1'b0;
    k = 0;
    while (cap_n < 64 && k < 3000) begin
      w_ready = (k < 2) ? 1'b0 : 1'(($urandom_range(0, 1)));
      step();
      k++;
    end
    w_ready = 1'b1;
    check("bp_done", cap_n, 64);
    repeat (3) step();
    check("bp_w17", cap_w[17], 32'h000F0000);
    check("bp_w63_last", {cap_l[63], cap_k[63]}, {1'b1, 32'hc67178f2});

    // Back-to-back: block_valid held high, second block waits out the first
    block_valid = 1'b1; block_data = ABC_BLK;
    step();
    block_data = blk2;
    wait_last();
    @(negedge clk);
    check("b2b_bubble", {w_valid, block_ready}, {1'b0, 1'b1});
    @(negedge clk);
    check("b2b_second", {w_valid, round_idx, w_data}, {1'b1, 6'd0, 32'hdeadbe00});
    step();
    block_valid = 1'b0;
    wait_last();
    repeat (3) step();

    // Reset at t=30
    block_valid = 1'b1; block_data = ABC_BLK;
    step();
    block_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (round_idx !== 6'd30 && k < 200);
    check("saw_t30", round_idx, 6'd30);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid", {w_valid, block_ready, w_data, round_idx}, {1'b0, 1'b1, 32'h0, 6'd0});
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", w_valid, 1'b0);
    end
    step();
    block_valid = 1'b1; block_data = blk2;
    step();
    check("post_rst_w0", {w_valid, round_idx, w_data}, {1'b1, 6'd0, 32'hdeadbe00});
    block_valid = 1'b0;
    wait_last();
    repeat (3) step();

    // ROUNDS=16: words pass through verbatim
    bv16 = 1'b1; bd16 = blk2;
    step();
    bv16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("r16_word", {wv16, wd16, ri16, wl16},
            {1'b1, 32'hdeadbe00 + 32'h01000000 * i, 6'(i), i == 15});
      step();
    end
    check("r16_done", {wv16, br16, wd16}, {1'b0, 1'b1, 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
